// File: rtl/sephirot_stack_pkg.sv
// Shared lane count, FSM encoding and counter helpers for the Sephirot stack controller.
package sephirot_stack_pkg;

  localparam int NUM_LANES = 4;
  localparam int STK_AW    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } stk_state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [2:0] inc);
    logic [32:0] sum;
    sum       = {1'b0, acc} + {30'd0, inc};
    sat_add32 = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/stack_wr_arb.sv
// Per-cycle lane write arbitration: bounds check, same-address conflict resolution
// (the later VLIW slot wins) and the resulting survivor mask. Purely combinational.
module stack_wr_arb
  import sephirot_stack_pkg::*;
#(
  parameter int MAX_ENTRIES = 64,
  parameter int LANE_AW     = 16
) (
  input  logic [NUM_LANES-1:0]         req_i,
  input  logic [NUM_LANES*LANE_AW-1:0] addr_i,
  output logic [NUM_LANES-1:0]         oob_o,
  output logic [NUM_LANES-1:0]         conflict_o,
  output logic [NUM_LANES-1:0]         survive_o
);

  logic [NUM_LANES-1:0] inb_s;

  always_comb begin
    oob_o      = '0;
    inb_s      = '0;
    conflict_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req_i[i]) begin
        if (32'(addr_i[i*LANE_AW +: LANE_AW]) >= 32'(MAX_ENTRIES)) begin
          oob_o[i] = 1'b1;
        end else begin
          inb_s[i] = 1'b1;
        end
      end else begin
        oob_o[i] = 1'b0;
      end
    end
    // Out-of-bounds lanes never take part in conflicts.
    for (int i = 0; i < NUM_LANES - 1; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (inb_s[i] && inb_s[j] &&
            (addr_i[i*LANE_AW +: LANE_AW] == addr_i[j*LANE_AW +: LANE_AW])) begin
          conflict_o[i] = 1'b1;
        end else begin
          conflict_o[i] = conflict_o[i];
        end
      end
    end
    survive_o = inb_s & ~conflict_o;
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack write-port sequencer: zero-fills the stack on every packet start, then registers
// arbitrated lane writes. Define STACK_CTRL_STATS_EN to build the conflict/OOB counters.
module stack_ctrl
  import sephirot_stack_pkg::*;
#(
  parameter int VALUE_SIZE  = 64,
  parameter int MAX_ENTRIES = 64,
  parameter int LANE_AW     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pkt_start,
  output logic                            stall,
  output logic                            clear_done,
  input  logic [NUM_LANES-1:0]            lane_wr_en,
  input  logic [NUM_LANES*LANE_AW-1:0]    lane_wr_addr,
  input  logic [NUM_LANES*VALUE_SIZE-1:0] lane_wr_data,
  output logic [NUM_LANES-1:0]            stk_wr_en,
  output logic [NUM_LANES*STK_AW-1:0]     stk_wr_addr,
  output logic [NUM_LANES*VALUE_SIZE-1:0] stk_wr_data,
  output logic                            oob_fault,
  output logic                            wr_conflict,
  output logic [31:0]                     conflict_cnt,
  output logic [31:0]                     oob_cnt
);

  localparam int            PW       = $clog2(MAX_ENTRIES);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_ENTRIES - 4);
  localparam logic [PW-1:0] PTR_STEP = PW'(NUM_LANES);

  stk_state_e                      state_q, state_d;
  logic [PW-1:0]                   clr_ptr_q, clr_ptr_d;
  logic                            clear_done_q, clear_done_d;
  logic [NUM_LANES-1:0]            stk_en_q, stk_en_d;
  logic [NUM_LANES*STK_AW-1:0]     stk_addr_q, stk_addr_d;
  logic [NUM_LANES*VALUE_SIZE-1:0] stk_data_q, stk_data_d;
  logic                            oob_fault_q, oob_fault_d;
  logic                            wr_conflict_q, wr_conflict_d;
  logic [NUM_LANES-1:0]            arb_oob_s, arb_conflict_s, arb_survive_s;
  logic                            run_s;

  stack_wr_arb #(
    .MAX_ENTRIES(MAX_ENTRIES),
    .LANE_AW    (LANE_AW)
  ) u_arb (
    .req_i     (lane_wr_en),
    .addr_i    (lane_wr_addr),
    .oob_o     (arb_oob_s),
    .conflict_o(arb_conflict_s),
    .survive_o (arb_survive_s)
  );

  assign run_s = (state_q == RUN);

  // FSM state and clear pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // A pkt_start always restarts the clear, even on its final beat.
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_start) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (pkt_start) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == LAST_PTR) begin
          state_d      = RUN;
          clr_ptr_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + PTR_STEP;
        end
      end
      RUN: begin
        if (pkt_start) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_comb begin
    stall      = (state_q != RUN);
    stk_en_d   = '0;
    stk_addr_d = '0;
    stk_data_d = '0;
    case (state_q)
      CLEAR: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          stk_en_d[i]                    = 1'b1;
          stk_addr_d[i*STK_AW +: STK_AW] = STK_AW'(clr_ptr_q + PW'(i));
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (arb_survive_s[i]) begin
            stk_en_d[i]                            = 1'b1;
            stk_addr_d[i*STK_AW +: STK_AW]         = STK_AW'(lane_wr_addr[i*LANE_AW +: LANE_AW]);
            stk_data_d[i*VALUE_SIZE +: VALUE_SIZE] = lane_wr_data[i*VALUE_SIZE +: VALUE_SIZE];
          end else begin
            stk_en_d[i] = 1'b0;
          end
        end
      end
      default: begin
        stk_en_d = '0;
      end
    endcase
    oob_fault_d   = pkt_start ? 1'b0 : (oob_fault_q | (run_s & (|arb_oob_s)));
    wr_conflict_d = run_s & (|arb_conflict_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_done_q  <= 1'b0;
      stk_en_q      <= '0;
      stk_addr_q    <= '0;
      stk_data_q    <= '0;
      oob_fault_q   <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      clear_done_q  <= clear_done_d;
      stk_en_q      <= stk_en_d;
      stk_addr_q    <= stk_addr_d;
      stk_data_q    <= stk_data_d;
      oob_fault_q   <= oob_fault_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign clear_done  = clear_done_q;
  assign stk_wr_en   = stk_en_q;
  assign stk_wr_addr = stk_addr_q;
  assign stk_wr_data = stk_data_q;
  assign oob_fault   = oob_fault_q;
  assign wr_conflict = wr_conflict_q;

`ifdef STACK_CTRL_STATS_EN
  logic [31:0] conflict_cnt_q, oob_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= 32'd0;
      oob_cnt_q      <= 32'd0;
    end else if (pkt_start) begin
      conflict_cnt_q <= 32'd0;
      oob_cnt_q      <= 32'd0;
    end else if (run_s) begin
      conflict_cnt_q <= sat_add32(conflict_cnt_q, popcount4(arb_conflict_s));
      oob_cnt_q      <= sat_add32(oob_cnt_q, popcount4(arb_oob_s));
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign oob_cnt      = oob_cnt_q;
`else
  assign conflict_cnt = 32'd0;
  assign oob_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized self-checking bench for stack_ctrl against a behavioural model of the
// clear sequence and lane arbitration, plus directed literal checks of the key scenarios.
module tb_stack_ctrl;

  localparam int VS = 64;
  localparam int ME = 64;
  localparam int AW = 16;
`ifdef STACK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;

  logic          clk, reset, pkt_start, stall, clear_done, oob_fault, wr_conflict;
  logic [3:0]    lane_wr_en, stk_wr_en;
  logic [4*AW-1:0] lane_wr_addr;
  logic [4*VS-1:0] lane_wr_data, stk_wr_data;
  logic [4*64-1:0] stk_wr_addr;
  logic [31:0]   conflict_cnt, oob_cnt;

  int checks = 0;
  int failures = 0;

  stack_ctrl #(.VALUE_SIZE(VS), .MAX_ENTRIES(ME), .LANE_AW(AW)) dut (
    .clk(clk), .reset(reset), .pkt_start(pkt_start), .stall(stall), .clear_done(clear_done),
    .lane_wr_en(lane_wr_en), .lane_wr_addr(lane_wr_addr), .lane_wr_data(lane_wr_data),
    .stk_wr_en(stk_wr_en), .stk_wr_addr(stk_wr_addr), .stk_wr_data(stk_wr_data),
    .oob_fault(oob_fault), .wr_conflict(wr_conflict),
    .conflict_cnt(conflict_cnt), .oob_cnt(oob_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase, m_beat;
  logic        m_stall, m_done, m_oob, m_conf;
  logic [3:0]  m_en;
  logic [63:0] m_addr[4];
  logic [63:0] m_data[4];
  longint      m_ccnt, m_ocnt;

  task automatic model_step();
    int nconf, noob, ntaken, a;
    int taken[4];
    bit dup;
    m_en = 4'd0; m_done = 1'b0; nconf = 0; noob = 0; ntaken = 0;
    for (int i = 0; i < 4; i++) begin m_addr[i] = 64'd0; m_data[i] = 64'd0; taken[i] = -1; end
    if (reset) begin
      m_phase = P_IDLE; m_beat = 0; m_oob = 1'b0; m_conf = 1'b0;
      m_ccnt = 0; m_ocnt = 0; m_stall = 1'b1;
      return;
    end
    if (m_phase == P_CLEAR) begin
      for (int i = 0; i < 4; i++) begin m_en[i] = 1'b1; m_addr[i] = 64'(m_beat * 4 + i); end
    end else if (m_phase == P_RUN) begin
      // Walk from the last slot down: an address already claimed by a later slot loses.
      for (int i = 3; i >= 0; i--) begin
        if (lane_wr_en[i]) begin
          a = int'(lane_wr_addr[i*AW +: AW]);
          dup = 1'b0;
          for (int k = 0; k < ntaken; k++) if (taken[k] == a) dup = 1'b1;
          if (a >= ME) noob++;
          else if (dup) nconf++;
          else begin
            taken[ntaken] = a; ntaken++;
            m_en[i] = 1'b1; m_addr[i] = 64'(a); m_data[i] = lane_wr_data[i*VS +: VS];
          end
        end
      end
    end
    m_conf = (nconf > 0);
    if (pkt_start) begin
      m_phase = P_CLEAR; m_beat = 0; m_oob = 1'b0; m_ccnt = 0; m_ocnt = 0;
    end else begin
      if (noob > 0) m_oob = 1'b1;
      if (STATS) begin
        m_ccnt = (m_ccnt + nconf > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ccnt + nconf;
        m_ocnt = (m_ocnt + noob > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ocnt + noob;
      end
      if (m_phase == P_CLEAR) begin
        if (m_beat == ME / 4 - 1) begin m_phase = P_RUN; m_done = 1'b1; end
        else m_beat++;
      end
    end
    m_stall = (m_phase != P_RUN);
  endtask

  // Every-cycle comparison against the model, sampled 1 time unit after the edge.
  initial begin : compare
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("stall", 64'(stall), 64'(m_stall));
      chk("clear_done", 64'(clear_done), 64'(m_done));
      chk("stk_wr_en", 64'(stk_wr_en), 64'(m_en));
      chk("oob_fault", 64'(oob_fault), 64'(m_oob));
      chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_ccnt));
      chk("oob_cnt", 64'(oob_cnt), 64'(m_ocnt));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("stk_wr_addr[%0d]", i), stk_wr_addr[i*64 +: 64], m_addr[i]);
        chk($sformatf("stk_wr_data[%0d]", i), stk_wr_data[i*VS +: VS], m_data[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_lanes();
    lane_wr_en = 4'd0; lane_wr_addr = '0; lane_wr_data = '0;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      lane_wr_en[i] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       lane_wr_addr[i*AW +: AW] = 16'($urandom);
        1:       lane_wr_addr[i*AW +: AW] = 16'(ME + $urandom_range(0, 2));
        default: lane_wr_addr[i*AW +: AW] = 16'($urandom_range(0, 5));
      endcase
      lane_wr_data[i*VS +: VS] = {$urandom, $urandom};
    end
  endtask

  // Start a clear (optionally restarting it at beat restart_beat) and run until clear_done.
  task automatic run_clear(input int restart_beat);
    int n, start;
    pkt_start = 1'b1; idle_lanes();
    @(negedge clk);
    pkt_start = 1'b0; n = 1; start = 0;
    chk("oob_fault_after_pkt_start", 64'(oob_fault), 64'd0);
    chk("oob_cnt_after_pkt_start", 64'(oob_cnt), 64'd0);
    chk("conflict_cnt_after_pkt_start", 64'(conflict_cnt), 64'd0);
    while (!clear_done && n < 60) begin
      chk("stall_in_clear", 64'(stall), 64'd1);
      if (n >= start + 2) begin
        chk("clear_en", 64'(stk_wr_en), 64'hF);
        chk("clear_addr0", stk_wr_addr[63:0], 64'(4 * (n - start - 2)));
        chk("clear_data2", stk_wr_data[2*VS +: VS], 64'd0);
      end
      rand_lanes();
      if (n == restart_beat + 1) begin pkt_start = 1'b1; start = n; end
      @(negedge clk);
      pkt_start = 1'b0; n++;
    end
    idle_lanes();
    chk("clear_done_latency", 64'(n - start), 64'd17);
    chk("stall_after_clear", 64'(stall), 64'd0);
    chk("last_beat_en", 64'(stk_wr_en), 64'hF);
    chk("last_beat_addr3", stk_wr_addr[3*64 +: 64], 64'(ME - 1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; pkt_start = 1'b0; idle_lanes();
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd1);
    chk("rst_en", 64'(stk_wr_en), 64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);
    chk("rst_oob", 64'(oob_fault), 64'd0);
    reset = 1'b0;
    // IDLE drops lane writes
    repeat (3) begin
      rand_lanes(); @(negedge clk);
      chk("idle_en", 64'(stk_wr_en), 64'd0);
    end

    // Scenario 1: plain clear
    run_clear(-1);

    // Scenario 2: four distinct in-bounds writes
    lane_wr_en = 4'hF;
    lane_wr_addr = {16'd8, 16'd7, 16'd6, 16'd5};
    lane_wr_data = {64'hD, 64'hC, 64'hB, 64'hA};
    @(negedge clk);
    idle_lanes();
    chk("s2_en", 64'(stk_wr_en), 64'hF);
    chk("s2_addr0", stk_wr_addr[63:0], 64'd5);
    chk("s2_addr3", stk_wr_addr[3*64 +: 64], 64'd8);
    chk("s2_data1", stk_wr_data[1*VS +: VS], 64'hB);
    chk("s2_conflict", 64'(wr_conflict), 64'd0);
    chk("s2_oob", 64'(oob_fault), 64'd0);

    // Scenario 3: lanes 0,2,3 hit address 10, lane 1 address 11
    lane_wr_en = 4'hF;
    lane_wr_addr = {16'd10, 16'd10, 16'd11, 16'd10};
    lane_wr_data = {64'h33, 64'h22, 64'h11, 64'h00};
    @(negedge clk);
    idle_lanes();
    chk("s3_en", 64'(stk_wr_en), 64'b1010);
    chk("s3_addr1", stk_wr_addr[1*64 +: 64], 64'd11);
    chk("s3_addr3", stk_wr_addr[3*64 +: 64], 64'd10);
    chk("s3_data3", stk_wr_data[3*VS +: VS], 64'h33);
    chk("s3_addr0_zero", stk_wr_addr[63:0], 64'd0);
    chk("s3_conflict", 64'(wr_conflict), 64'd1);
    chk("s3_conflict_cnt", 64'(conflict_cnt), STATS ? 64'd2 : 64'd0);
    @(negedge clk);
    chk("s3_conflict_drop", 64'(wr_conflict), 64'd0);

    // Scenario 4: out-of-bounds lane 2
    lane_wr_en = 4'b0100;
    lane_wr_addr = {16'd0, 16'd64, 16'd0, 16'd0};
    @(negedge clk);
    idle_lanes();
    chk("s4_en", 64'(stk_wr_en), 64'd0);
    chk("s4_oob", 64'(oob_fault), 64'd1);
    chk("s4_oob_cnt", 64'(oob_cnt), STATS ? 64'd1 : 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("s4_oob_sticky", 64'(oob_fault), 64'd1);
    end

    // Scenario 5: restart mid-clear, then restart on the final beat
    run_clear(9);
    run_clear(15);

    // Scenario 6: async reset between edges during a clear
    pkt_start = 1'b1; @(negedge clk); pkt_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s6_stall", 64'(stall), 64'd1);
    chk("s6_en", 64'(stk_wr_en), 64'd0);
    chk("s6_addr0", stk_wr_addr[63:0], 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      rand_lanes(); @(negedge clk);
      chk("s6_idle_stall", 64'(stall), 64'd1);
      chk("s6_idle_en", 64'(stk_wr_en), 64'd0);
    end
    idle_lanes();

    // Random traffic with occasional packet starts
    run_clear(-1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) begin pkt_start = 1'b1; idle_lanes(); end
      else begin pkt_start = 1'b0; rand_lanes(); end
      @(negedge clk);
    end
    pkt_start = 1'b0; idle_lanes();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
